// File: rtl/mem_loader_if.sv
// mem_loader memory port bundle toward ram7.
// master: loader side; slave: memory side.
`timescale 1ns/1ps
interface mem_loader_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic [15:0] mem_d_out;

  modport master (
    output mem_addr,
    output mem_din,
    output mem_we,
    input  mem_d_out
  );

  modport slave (
    input  mem_addr,
    input  mem_din,
    input  mem_we,
    output mem_d_out
  );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: front-panel address set / deposit / readback engine.
// Ports: clk, reset (async low), en, sw, ld_adr, ld_dat, rd pulses,
// mem (ram7 port, master), disp_adr, disp_dat, busy, wrapped.
`timescale 1ns/1ps
module mem_loader #(
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [15:0]   sw,
  input  logic          ld_adr,
  input  logic          ld_dat,
  input  logic          rd,
  mem_loader_if.master  mem,
  output logic [15:0]   disp_adr,
  output logic [15:0]   disp_dat,
  output logic          busy,
  output logic          wrapped
);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    CAP
  } state_t;

  localparam logic [2:0] LAST = 3'(RD_LAT - 1);

  state_t      state;
  logic [15:0] addr;
  logic [15:0] din;
  logic        we_q;
  logic [15:0] dat;
  logic        wrap;
  logic [2:0]  cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      addr  <= '0;
      din   <= '0;
      we_q  <= 1'b0;
      dat   <= '0;
      wrap  <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            if (ld_adr) begin
              addr  <= sw;
              wrap  <= 1'b0;
              state <= RD;
            end else if (ld_dat) begin
              din   <= sw;
              we_q  <= 1'b1;
              state <= WR;
            end else if (rd) begin
              state <= RD;
            end
          end
        end
        WR: begin
          we_q  <= 1'b0;
          addr  <= addr + 16'd1;
          if (addr == 16'hFFFF)
            wrap <= 1'b1;
          state <= RD;
        end
        RD: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= CAP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        CAP: begin
          dat   <= mem.mem_d_out;
          state <= IDLE;
        end
      endcase
    end
  end

  // en low hands the port back to the CPU at once,
  // even mid-write
  assign mem.mem_we   = we_q & en;
  assign mem.mem_addr = addr;
  assign mem.mem_din  = din;
  assign disp_adr     = addr;
  assign disp_dat     = dat;
  assign busy         = (state != IDLE);
  assign wrapped      = wrap;

endmodule
